// File: rtl/instructie_pkg.sv
// instructie_pkg -- shared constants for the execute sequencer.
//   Opcode values (instruction bits [4:0]), immediate-select bit index,
//   one-hot ALU operation codes, FSM state encoding and the decoder
//   output struct.
//   Optional feature macro used elsewhere: DECODER_FLAGS_EN.
package instructie_pkg;

  // Operation field, instruction bits [4:0]
  localparam logic [4:0] OPC_NOP = 5'd0;
  localparam logic [4:0] OPC_ADD = 5'd1;
  localparam logic [4:0] OPC_SUB = 5'd2;
  localparam logic [4:0] OPC_XOR = 5'd3;
  localparam logic [4:0] OPC_OR  = 5'd4;
  localparam logic [4:0] OPC_AND = 5'd5;
  localparam logic [4:0] OPC_NOT = 5'd6;

  // Instruction bit selecting an immediate B operand
  localparam int IMM_BIT = 5;
  // Instruction bits at and above this index must be zero
  localparam int RSVD_LSB = 6;

  // One-hot ALU operation codes
  localparam logic [5:0] ALU_NONE = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b001000;
  localparam logic [5:0] ALU_SUB  = 6'b010000;
  localparam logic [5:0] ALU_XOR  = 6'b100000;
  localparam logic [5:0] ALU_OR   = 6'b000010;
  localparam logic [5:0] ALU_AND  = 6'b000100;
  localparam logic [5:0] ALU_NOT  = 6'b000001;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD_A = 3'd1;
  localparam state_t ST_RD_B = 3'd2;
  localparam state_t ST_EXEC = 3'd3;
  localparam state_t ST_WB   = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  // Decoded instruction
  typedef struct packed {
    logic [5:0] alu_op;  // one-hot ALU op, ALU_NONE for NOP/illegal
    logic       imm;     // B operand comes from argument2
    logic       nop;     // legal no-operation
    logic       legal;   // opcode is defined and reserved bits are zero
  } dec_t;

endpackage

// File: rtl/instructie_opdecode.sv
// instructie_opdecode -- combinational opcode decoder.
//   op  in  OP_W   raw instruction word
//   dec out dec_t  {alu_op, imm, nop, legal}
// Any set bit above the immediate-select bit makes the instruction illegal,
// as does an operation field outside NOP..NOT.
module instructie_opdecode
  import instructie_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  logic rsvd;
  assign rsvd = |(op >> RSVD_LSB);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_NONE;
    dec.imm    = op[IMM_BIT];
    case (op[4:0])
      OPC_NOP: begin dec.nop = 1'b1;     dec.legal = 1'b1; end
      OPC_ADD: begin dec.alu_op = ALU_ADD; dec.legal = 1'b1; end
      OPC_SUB: begin dec.alu_op = ALU_SUB; dec.legal = 1'b1; end
      OPC_XOR: begin dec.alu_op = ALU_XOR; dec.legal = 1'b1; end
      OPC_OR:  begin dec.alu_op = ALU_OR;  dec.legal = 1'b1; end
      OPC_AND: begin dec.alu_op = ALU_AND; dec.legal = 1'b1; end
      OPC_NOT: begin dec.alu_op = ALU_NOT; dec.legal = 1'b1; end
      default: dec.legal = 1'b0;
    endcase
    if (rsvd) begin
      dec.legal  = 1'b0;
      dec.nop    = 1'b0;
      dec.alu_op = ALU_NONE;
    end
  end

endmodule

// File: rtl/instructie_executer.sv
// instructie_executer -- multi-cycle execute sequencer for two-operand
// register/immediate instructions.
//   clock, reset (async, active high)
//   instr_valid/instr_ready  handshake with fetch; ready only in IDLE
//   instructie, argument1, argument2  instruction and operands, latched at accept
//   reg_ce/reg_we/reg_addr/reg_wdata/reg_rdata  register file port
//   alu_a/alu_b/alu_op/alu_result  external combinational ALU
//   result   last written-back value
//   done     one-cycle completion pulse; illegal coincides for bad opcodes
//   flag_z/flag_n  only when DECODER_FLAGS_EN is defined
// Sequence after accept (T0): RD_A(T1) RD_B(T2) EXEC(T3) WB(T4) IDLE(T5).
// All register-file strobes are registered, so the address presented in a
// state is the one the file sees during that state; the read data it returns
// is captured at the edge that closes the strobe cycle.
module instructie_executer
  import instructie_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int REG_COUNT = 16,
  parameter  int OP_W      = 8,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instructie,
  input  logic [DATA_W-1:0] argument1,
  input  logic [DATA_W-1:0] argument2,
  output logic              reg_ce,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] result,
`ifdef DECODER_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  output logic              done,
  output logic              illegal
);

  state_t              state;
  dec_t                dec;
  logic                imm_q;
  logic [REG_AW-1:0]   a1_q;
  logic [DATA_W-1:0]   a2_q;

  // Only the low REG_AW bits of argument1 address the register file
  logic unused_arg1;
  assign unused_arg1 = ^argument1[DATA_W-1:REG_AW];

  instructie_opdecode #(.OP_W(OP_W)) u_dec (
    .op  (instructie),
    .dec (dec)
  );

  assign instr_ready = (state == ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      imm_q     <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      reg_ce    <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= ALU_NONE;
      result    <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            a1_q  <= argument1[REG_AW-1:0];
            a2_q  <= argument2;
            imm_q <= dec.imm;
            if (dec.legal && !dec.nop) begin
              state    <= ST_RD_A;
              reg_ce   <= 1'b1;
              reg_we   <= 1'b0;
              reg_addr <= argument1[REG_AW-1:0];
              alu_op   <= dec.alu_op;
            end else begin
              // NOP/illegal: finish in one cycle, never touch the register file
              state   <= ST_DONE;
              done    <= 1'b1;
              illegal <= ~dec.legal;
            end
          end
        end
        ST_RD_A: begin
          alu_a <= reg_rdata;
          state <= ST_RD_B;
          if (imm_q) begin
            reg_ce <= 1'b0;
            alu_b  <= a2_q;
          end else begin
            reg_addr <= a2_q[REG_AW-1:0];
          end
        end
        ST_RD_B: begin
          // B is read before any write-back, so arg1==arg2 sees the old value
          if (!imm_q) alu_b <= reg_rdata;
          reg_ce <= 1'b0;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          result    <= alu_result;
          reg_wdata <= alu_result;
          reg_ce    <= 1'b1;
          reg_we    <= 1'b1;
          reg_addr  <= a1_q;
          done      <= 1'b1;
          state     <= ST_WB;
        end
        ST_WB: begin
          reg_ce <= 1'b0;
          reg_we <= 1'b0;
          done   <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          reg_ce  <= 1'b0;
          reg_we  <= 1'b0;
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DECODER_FLAGS_EN
  // Flags follow the value being written back; NOP/illegal never reach WB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state == ST_WB) begin
      flag_z <= (result == '0);
      flag_n <= result[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_instructie_executer.sv
module tb_instructie_executer;
  import instructie_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instructie;
  logic [15:0] argument1, argument2;
  logic        reg_ce, reg_we;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic [15:0] alu_a, alu_b, alu_result, result;
  logic [5:0]  alu_op;
  logic        done, illegal;
`ifdef DECODER_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  always #5 clock = ~clock;

  instructie_executer #(.DATA_W(16), .REG_COUNT(16), .OP_W(8)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instructie(instructie), .argument1(argument1), .argument2(argument2),
    .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .result(result),
`ifdef DECODER_FLAGS_EN
    .flag_z(flag_z), .flag_n(flag_n),
`endif
    .done(done), .illegal(illegal)
  );

  // Register file: data for the strobed address while a read strobe is up,
  // garbage otherwise; writes land on the clock edge.
  logic [15:0] mem [16];
  logic        poke_en;
  logic [3:0]  poke_addr;
  logic [15:0] poke_data;
  assign reg_rdata = (reg_ce && !reg_we) ? mem[reg_addr] : 16'hDEAD;
  always @(posedge clock) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (reg_ce && reg_we) mem[reg_addr] <= reg_wdata;
  end

  // ALU
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_NOT: alu_result = ~alu_a;
      default: alu_result = 16'h0000;
    endcase
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Per-instruction observation, cycle k counted from the accept edge (T0)
  int          wr_cyc, done_cyc, rdy_cyc;
  logic [15:0] wr_data, a_s, b_s;
  logic [3:0]  wr_addr;
  logic        ce_seen, ill_seen;

  task automatic run(input logic [7:0] op, input logic [15:0] a1, input logic [15:0] a2);
    @(negedge clock);
    instr_valid = 1'b1; instructie = op; argument1 = a1; argument2 = a2;
    wr_cyc = 0; done_cyc = 0; rdy_cyc = 0; ce_seen = 1'b0; ill_seen = 1'b0;
    wr_data = '0; wr_addr = '0; a_s = '0; b_s = '0;
    @(posedge clock);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) begin
        // scramble inputs: nothing may be sampled after T0
        instr_valid = 1'b0; instructie = 8'hFF; argument1 = 16'hFFFF; argument2 = 16'hFFFF;
      end
      if (reg_ce) ce_seen = 1'b1;
      if (reg_ce && reg_we && wr_cyc == 0) begin wr_cyc = k; wr_data = reg_wdata; wr_addr = reg_addr; end
      if (done && done_cyc == 0) begin done_cyc = k; ill_seen = illegal; end
      if (k == 3) begin a_s = alu_a; b_s = alu_b; end
      if (instr_ready && done_cyc != 0 && rdy_cyc == 0) rdy_cyc = k;
    end
  endtask

  int          w1, w2, d_cnt;
  logic [15:0] d1, d2;
  logic        seen_done, seen_we;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instructie = '0; argument1 = '0; argument2 = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ctrl", {instr_ready, reg_ce, reg_we, done, illegal}, 5'b10000);
    chk("rst_addr_op", {reg_addr, alu_op}, 10'h000);
    chk("rst_data", {reg_wdata, result}, 32'h0);
    chk("rst_alu", {alu_a, alu_b}, 32'h0);
    reset = 1'b0;

    poke(4'd1, 16'd5);    poke(4'd2, 16'd7);    poke(4'd3, 16'hFFFF);
    poke(4'd4, 16'd3);    poke(4'd5, 16'd5);    poke(4'd6, 16'h00F0);
    poke(4'd7, 16'h0F0F); poke(4'd8, 16'h1200); poke(4'd9, 16'h0034);
    poke(4'd10, 16'h1111); poke(4'd11, 16'h2222); poke(4'd0, 16'h5555);

    // ADD register mode: r1 = 5 + 7
    run(8'h01, 16'd1, 16'd2);
    chk("add_wr_cyc", wr_cyc, 4);
    chk("add_wr_addr", wr_addr, 4'd1);
    chk("add_wr_data", wr_data, 16'h000C);
    chk("add_done_cyc", done_cyc, 4);
    chk("add_illegal", ill_seen, 1'b0);
    chk("add_ready_cyc", rdy_cyc, 5);
    chk("add_ops", {a_s, b_s}, {16'd5, 16'd7});
    chk("add_result", result, 16'h000C);
    chk("add_mem", mem[1], 16'h000C);

    // ADD immediate with wrap: r3 = 0xFFFF + 1
    run(8'h21, 16'd3, 16'd1);
    chk("addi_b", b_s, 16'd1);
    chk("addi_mem", mem[3], 16'h0000);
    chk("addi_result", result, 16'h0000);
    chk("addi_done_cyc", done_cyc, 4);
`ifdef DECODER_FLAGS_EN
    chk("addi_flags", {flag_z, flag_n}, 2'b10);
`endif

    // SUB register mode: r4 = 3 - 5
    run(8'h02, 16'd4, 16'd5);
    chk("sub_mem", mem[4], 16'hFFFE);
    chk("sub_result", result, 16'hFFFE);
`ifdef DECODER_FLAGS_EN
    chk("sub_flags", {flag_z, flag_n}, 2'b01);
`endif

    // Undefined operation field
    run(8'h1F, 16'd1, 16'd2);
    chk("ill1f_done_cyc", done_cyc, 1);
    chk("ill1f_illegal", ill_seen, 1'b1);
    chk("ill1f_no_ce", ce_seen, 1'b0);
    chk("ill1f_ready_cyc", rdy_cyc, 2);
    chk("ill1f_result", result, 16'hFFFE);

    // Reserved bit 6 set on an otherwise valid ADD
    run(8'h41, 16'd1, 16'd2);
    chk("ill41_done_cyc", done_cyc, 1);
    chk("ill41_illegal", ill_seen, 1'b1);
    chk("ill41_no_ce", ce_seen, 1'b0);
    chk("ill41_result", result, 16'hFFFE);
    chk("ill41_mem", mem[1], 16'h000C);
`ifdef DECODER_FLAGS_EN
    chk("ill_flags_kept", {flag_z, flag_n}, 2'b01);
`endif

    // NOP
    run(8'h00, 16'd1, 16'd2);
    chk("nop_done_cyc", done_cyc, 1);
    chk("nop_illegal", ill_seen, 1'b0);
    chk("nop_no_ce", ce_seen, 1'b0);

    // OR register mode: r8 = 0x1200 | 0x0034
    run(8'h04, 16'd8, 16'd9);
    chk("or_mem", mem[8], 16'h1234);

    // XOR with destination == source B: reads pre-write value, result 0
    run(8'h03, 16'd7, 16'd7);
    chk("xor_same_mem", mem[7], 16'h0000);
`ifdef DECODER_FLAGS_EN
    chk("xor_flags", {flag_z, flag_n}, 2'b10);
`endif

    // Reset asserted during RD_B
    @(negedge clock);
    instr_valid = 1'b1; instructie = 8'h01; argument1 = 16'd10; argument2 = 16'd11;
    @(posedge clock);
    @(negedge clock); instr_valid = 1'b0;  // T1
    @(negedge clock);                      // T2, B read strobe up
    chk("rst_mid_pre_ce", reg_ce, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", {reg_ce, reg_we, instr_ready, done}, 4'b0010);
    @(negedge clock); reset = 1'b0;
    seen_done = 1'b0; seen_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
      if (reg_we) seen_we = 1'b1;
    end
    chk("rst_mid_no_done_we", {seen_done, seen_we}, 2'b00);
    chk("rst_mid_mem", mem[10], 16'h1111);
    chk("rst_mid_result", result, 16'h0000);

    // Back-to-back, valid held high: NOT r6 then AND r6, imm 0x0F0F
    @(negedge clock);
    instr_valid = 1'b1; instructie = 8'h06; argument1 = 16'd6; argument2 = 16'd0;
    w1 = 0; w2 = 0; d1 = '0; d2 = '0; d_cnt = 0;
    @(posedge clock);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (k == 1) begin instructie = 8'h25; argument1 = 16'd6; argument2 = 16'h0F0F; end
      if (k == 6) instr_valid = 1'b0;
      if (done) d_cnt++;
      if (reg_ce && reg_we) begin
        if (w1 == 0) begin w1 = k; d1 = reg_wdata; end
        else if (w2 == 0) begin w2 = k; d2 = reg_wdata; end
      end
    end
    chk("b2b_wr1_cyc", w1, 4);
    chk("b2b_wr1_data", d1, 16'hFF0F);
    chk("b2b_wr2_cyc", w2, 9);
    chk("b2b_wr2_data", d2, 16'h0F0F);
    chk("b2b_done_cnt", d_cnt, 2);
    chk("b2b_mem", mem[6], 16'h0F0F);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
